// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the write-slave state encoding.
// Intended for reuse by the companion read slave.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         STRB_WIDTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RESP  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/axi4_lite_write_slave.sv
// AXI4-Lite write responder: collects one AW and one W beat in any order, issues a
// single-cycle local write pulse when the address is in the window, then answers on B.
module axi4_lite_write_slave
  import axi4_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_RANGE = 32'h0000_1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [STRB_WIDTH-1:0] S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0] mem_wstrb
);

  wr_state_e             state_reg, state_next;
  logic                  aw_got_reg, aw_got_next;
  logic                  w_got_reg, w_got_next;
  logic [ADDR_WIDTH-1:0] addr_buf_reg, addr_buf_next;
  logic [DATA_WIDTH-1:0] data_buf_reg, data_buf_next;
  logic [STRB_WIDTH-1:0] strb_buf_reg, strb_buf_next;
  logic [1:0]            resp_reg, resp_next;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  in_range;

  // One extra bit keeps BASE_ADDR+ADDR_RANGE from wrapping at the top of the map.
  logic [ADDR_WIDTH:0]   addr_ext;
  logic [ADDR_WIDTH:0]   lo_ext;
  logic [ADDR_WIDTH:0]   hi_ext;

  assign addr_ext = {1'b0, addr_buf_reg};
  assign lo_ext   = {1'b0, BASE_ADDR};
  assign hi_ext   = {1'b0, BASE_ADDR} + {1'b0, ADDR_RANGE};
  assign in_range = (addr_ext >= lo_ext) && (addr_ext < hi_ext);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      aw_got_reg   <= 1'b0;
      w_got_reg    <= 1'b0;
      addr_buf_reg <= '0;
      data_buf_reg <= '0;
      strb_buf_reg <= '0;
      resp_reg     <= RESP_OKAY;
    end else begin
      state_reg    <= state_next;
      aw_got_reg   <= aw_got_next;
      w_got_reg    <= w_got_next;
      addr_buf_reg <= addr_buf_next;
      data_buf_reg <= data_buf_next;
      strb_buf_reg <= strb_buf_next;
      resp_reg     <= resp_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    aw_got_next   = aw_got_reg;
    w_got_next    = w_got_reg;
    addr_buf_next = addr_buf_reg;
    data_buf_next = data_buf_reg;
    strb_buf_next = strb_buf_reg;
    resp_next     = resp_reg;

    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    S_AXI_BRESP   = RESP_OKAY;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wstrb     = '0;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Readys stay low while reset is held, even though the flags already read clear.
        S_AXI_AWREADY = !aw_got_reg && !rst;
        S_AXI_WREADY  = !w_got_reg && !rst;
        aw_hs         = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs          = S_AXI_WVALID && S_AXI_WREADY;
        if (aw_hs) begin
          aw_got_next   = 1'b1;
          addr_buf_next = S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_got_next    = 1'b1;
          data_buf_next = S_AXI_WDATA;
          strb_buf_next = S_AXI_WSTRB;
        end
        if ((aw_got_reg || aw_hs) && (w_got_reg || w_hs)) begin
          state_next = ST_WRITE;
        end
      end

      ST_WRITE: begin
        mem_we      = in_range;
        mem_addr    = addr_buf_reg - BASE_ADDR;
        mem_wdata   = data_buf_reg;
        mem_wstrb   = strb_buf_reg;
        resp_next   = in_range ? RESP_OKAY : RESP_SLVERR;
        aw_got_next = 1'b0;
        w_got_next  = 1'b0;
        state_next  = ST_RESP;
      end

      ST_RESP: begin
        S_AXI_BVALID = 1'b1;
        S_AXI_BRESP  = resp_reg;
        if (S_AXI_BREADY) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next  = ST_IDLE;
        aw_got_next = 1'b0;
        w_got_next  = 1'b0;
      end
    endcase
  end

endmodule
